// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, cell encodings and the
// move controller state type.
package connect4_pkg;

  localparam int ROWS  = 7;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  typedef logic [1:0] cell_t;

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t P1    = 2'b01;
  localparam cell_t P2    = 2'b10;

  typedef enum logic [3:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PROBE,
    ST_WAIT,
    ST_CHECK,
    ST_WRITE,
    ST_SCAN,
    ST_DONE,
    ST_REJECT
  } mc_state_t;

endpackage

// File: rtl/move_controller.sv
// Owns every board RAM access: wipes the board, drops one piece per move into
// the lowest free row of a column, then streams the board out for a rescan.
module move_controller
  import connect4_pkg::*;
#(
  parameter int COLS  = connect4_pkg::COLS,
  parameter int ROWS  = connect4_pkg::ROWS,
  parameter int CELLS = connect4_pkg::CELLS
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  input  logic       clear_req,
  output logic [5:0] ram_address,
  output logic [1:0] ram_data,
  output logic       ram_wren,
  input  logic [1:0] ram_q,
  output logic       scan_enable,
  output logic [1:0] current_player,
  output logic [2:0] move_row,
  output logic       move_done,
  output logic       move_reject,
  output logic       busy
);

  localparam logic [5:0] LAST_CELL = 6'(CELLS - 1);
  localparam logic [2:0] TOP_ROW   = 3'(ROWS - 1);

  mc_state_t  state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       from_clear_q, from_clear_d;
  cell_t      player_q, player_d;
  logic [2:0] move_row_q, move_row_d;

  logic [5:0] addr_q, addr_d;
  cell_t      data_q, data_d;
  logic       wren_q, wren_d;
  logic       scan_q, scan_d;
  logic       ready_q, ready_d;
  logic       busy_q;
  logic       done_q, done_d;
  logic       reject_q, reject_d;

  function automatic logic [5:0] cell_addr(input logic [2:0] r, input logic [2:0] c);
    return 6'(r) * 6'(COLS) + 6'(c);
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    from_clear_d = from_clear_q;
    player_d     = player_q;
    move_row_d   = move_row_q;
    case (state_q)
      ST_CLEAR: begin
        player_d     = P1;
        from_clear_d = 1'b1;
        if (idx_q == LAST_CELL) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_IDLE: begin
        // A wipe request outranks a move arriving in the same cycle.
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end else if (move_valid) begin
          col_d   = move_col;
          row_d   = '0;
          state_d = (int'(move_col) >= COLS) ? ST_REJECT : ST_PROBE;
        end
      end
      ST_PROBE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (ram_q == EMPTY) begin
          state_d = ST_WRITE;
        end else if (row_q < TOP_ROW) begin
          row_d   = row_q + 3'd1;
          state_d = ST_PROBE;
        end else begin
          state_d = ST_REJECT;
        end
      end
      ST_WRITE: begin
        move_row_d   = row_q;
        from_clear_d = 1'b0;
        idx_d        = '0;
        state_d      = ST_SCAN;
      end
      ST_SCAN: begin
        // Index holds at the last cell rather than wrapping.
        if (idx_q == LAST_CELL) begin
          state_d = from_clear_q ? ST_IDLE : ST_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_DONE: begin
        player_d = (player_q == P1) ? P2 : P1;
        state_d  = ST_IDLE;
      end
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_CLEAR;
    endcase
  end

  // Output decode of the current state; registered below so every port is a flop.
  always_comb begin
    addr_d   = '0;
    data_d   = EMPTY;
    wren_d   = 1'b0;
    scan_d   = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        addr_d = idx_q;
        wren_d = 1'b1;
      end
      ST_IDLE: ready_d = 1'b1;
      ST_PROBE, ST_WAIT, ST_CHECK: addr_d = cell_addr(row_q, col_q);
      ST_WRITE: begin
        addr_d = cell_addr(row_q, col_q);
        data_d = player_q;
        wren_d = 1'b1;
      end
      ST_SCAN: begin
        addr_d = idx_q;
        scan_d = 1'b1;
      end
      ST_DONE:   done_d   = 1'b1;
      ST_REJECT: reject_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      from_clear_q <= 1'b1;
      player_q     <= P1;
      move_row_q   <= '0;
      addr_q       <= '0;
      data_q       <= EMPTY;
      wren_q       <= 1'b0;
      scan_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      from_clear_q <= from_clear_d;
      player_q     <= player_d;
      move_row_q   <= move_row_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      scan_q       <= scan_d;
      ready_q      <= ready_d;
      busy_q       <= ~ready_d;
      done_q       <= done_d;
      reject_q     <= reject_d;
    end
  end

  assign ram_address    = addr_q;
  assign ram_data       = data_q;
  assign ram_wren       = wren_q;
  assign scan_enable    = scan_q;
  assign move_ready     = ready_q;
  assign busy           = busy_q;
  assign current_player = player_q;
  assign move_row       = move_row_q;
  assign move_done      = done_q;
  assign move_reject    = reject_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: behavioural board RAM plus a write scoreboard
// of expected (address, data) pairs popped as the DUT writes.
module tb_move_controller;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic       move_ready;
  logic       clear_req = 1'b0;
  logic [5:0] ram_address;
  logic [1:0] ram_data;
  logic       ram_wren;
  logic [1:0] ram_q = 2'b00;
  logic       scan_enable;
  logic [1:0] current_player;
  logic [2:0] move_row;
  logic       move_done;
  logic       move_reject;
  logic       busy;

  move_controller dut (
    .Clk(Clk), .reset(reset), .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .clear_req(clear_req), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .scan_enable(scan_enable), .current_player(current_player),
    .move_row(move_row), .move_done(move_done), .move_reject(move_reject),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Board RAM: registered read, data one cycle after the address.
  logic [1:0] mem [0:48] = '{default: 2'b11};
  always @(posedge Clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  localparam logic [18:0] RESET_OUTS = {1'b0, 1'b1, 6'd0, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 1'b0, 1'b0};

  int tests = 0;
  int failed = 0;
  logic [7:0] exp_q[$];
  int heights[7];
  logic [1:0] exp_player = 2'b01;

  int cyc_n, wr_cnt, last_wr_n, scan_cnt, scan_bad, done_n, rej_n, ready_n;

  task automatic clear_obs();
    cyc_n = 0; wr_cnt = 0; last_wr_n = -1; scan_cnt = 0; scan_bad = 0;
    done_n = -1; rej_n = -1; ready_n = -1;
  endtask

  task automatic push_clear();
    for (int i = 0; i < 49; i++) exp_q.push_back({6'(i), 2'b00});
    for (int c = 0; c < 7; c++) heights[c] = 0;
    exp_player = 2'b01;
  endtask

  // Advance one cycle and pop/compare any RAM write against the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(posedge Clk); #1;
    cyc_n++;
    if (ram_wren) begin
      wr_cnt++;
      last_wr_n = cyc_n;
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write cycle=%0d addr=%0d data=%b", cyc_n, ram_address, ram_data);
      end else begin
        e = exp_q.pop_front();
        if ({ram_address, ram_data} !== e) begin
          failed++;
          $display("FAIL write_sb cycle=%0d got addr=%0d data=%b exp addr=%0d data=%b",
                   cyc_n, ram_address, ram_data, e[7:2], e[1:0]);
        end
      end
    end
    if (scan_enable) begin
      if (ram_address !== 6'(scan_cnt)) scan_bad++;
      scan_cnt++;
    end
    if (move_done) done_n = cyc_n;
    if (move_reject) rej_n = cyc_n;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (move_ready) begin
        ready_n = cyc_n;
        break;
      end
    end
    tests++;
    if (ready_n < 0) begin
      failed++;
      $display("FAIL ready_timeout got none within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #20;
    tests++;
    if ({move_ready, busy, ram_address, ram_data, ram_wren, scan_enable, current_player,
         move_row, move_done, move_reject} !== RESET_OUTS) begin
      failed++;
      $display("FAIL reset_values got %b exp %b", {move_ready, busy, ram_address, ram_data,
               ram_wren, scan_enable, current_player, move_row, move_done, move_reject}, RESET_OUTS);
    end
    @(posedge Clk); #1;
    reset = 1'b1;
    push_clear();
    clear_obs();
    wait_ready(150);
    tests++; if (ready_n !== 99) begin failed++; $display("FAIL init_ready_cycle got %0d exp 99", ready_n); end
    tests++; if (wr_cnt !== 49) begin failed++; $display("FAIL init_writes got %0d exp 49", wr_cnt); end
    tests++; if (scan_cnt !== 49 || scan_bad !== 0) begin failed++; $display("FAIL init_scan got %0d cycles %0d bad exp 49 0", scan_cnt, scan_bad); end
    tests++; if (done_n !== -1) begin failed++; $display("FAIL init_no_done got %0d exp -1", done_n); end
    tests++; if (current_player !== 2'b01) begin failed++; $display("FAIL init_player got %b exp 01", current_player); end
  endtask

  task automatic test_drop(input int col, input string tag);
    int k;
    k = heights[col];
    exp_q.push_back({6'(k * 7 + col), exp_player});
    move_col = 3'(col);
    move_valid = 1'b1;
    @(posedge Clk); #1;
    move_valid = 1'b0;
    clear_obs();
    wait_ready(120);
    exp_player = (exp_player == 2'b01) ? 2'b10 : 2'b01;
    heights[col]++;
    tests++; if (last_wr_n !== 3*k+4) begin failed++; $display("FAIL %s write_cycle got %0d exp %0d", tag, last_wr_n, 3*k+4); end
    tests++; if (done_n !== 3*k+54) begin failed++; $display("FAIL %s done_cycle got %0d exp %0d", tag, done_n, 3*k+54); end
    tests++; if (ready_n !== 3*k+55) begin failed++; $display("FAIL %s ready_cycle got %0d exp %0d", tag, ready_n, 3*k+55); end
    tests++; if (scan_cnt !== 49 || scan_bad !== 0) begin failed++; $display("FAIL %s scan got %0d cycles %0d bad exp 49 0", tag, scan_cnt, scan_bad); end
    tests++; if (move_row !== 3'(k)) begin failed++; $display("FAIL %s move_row got %0d exp %0d", tag, move_row, k); end
    tests++; if (current_player !== exp_player) begin failed++; $display("FAIL %s player got %b exp %b", tag, current_player, exp_player); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL %s pending_writes got %0d exp 0", tag, exp_q.size()); end
  endtask

  task automatic test_full_column();
    for (int i = 0; i < 7; i++) test_drop(0, "fill_col0");
    move_col = 3'd0;
    move_valid = 1'b1;
    @(posedge Clk); #1;
    move_valid = 1'b0;
    clear_obs();
    wait_ready(60);
    tests++; if (rej_n !== 22) begin failed++; $display("FAIL full_reject_cycle got %0d exp 22", rej_n); end
    tests++; if (ready_n !== 23) begin failed++; $display("FAIL full_ready_cycle got %0d exp 23", ready_n); end
    tests++; if (wr_cnt !== 0 || done_n !== -1) begin failed++; $display("FAIL full_no_write got writes=%0d done=%0d exp 0 -1", wr_cnt, done_n); end
    tests++; if (current_player !== exp_player) begin failed++; $display("FAIL full_player got %b exp %b", current_player, exp_player); end
  endtask

  task automatic test_invalid_col();
    move_col = 3'd7;
    move_valid = 1'b1;
    @(posedge Clk); #1;
    move_valid = 1'b0;
    clear_obs();
    wait_ready(20);
    tests++; if (rej_n !== 1) begin failed++; $display("FAIL bad_col_reject got %0d exp 1", rej_n); end
    tests++; if (ready_n !== 2) begin failed++; $display("FAIL bad_col_ready got %0d exp 2", ready_n); end
    tests++; if (wr_cnt !== 0 || current_player !== exp_player) begin failed++; $display("FAIL bad_col_side_effect got writes=%0d player=%b exp 0 %b", wr_cnt, current_player, exp_player); end
  endtask

  task automatic test_clear_priority();
    int dirty;
    push_clear();
    move_col = 3'd2;
    move_valid = 1'b1;
    clear_req = 1'b1;
    @(posedge Clk); #1;
    move_valid = 1'b0;
    clear_req = 1'b0;
    clear_obs();
    wait_ready(150);
    dirty = 0;
    for (int i = 0; i < 49; i++) if (mem[i] !== 2'b00) dirty++;
    tests++; if (ready_n !== 99) begin failed++; $display("FAIL clr_ready_cycle got %0d exp 99", ready_n); end
    tests++; if (wr_cnt !== 49 || done_n !== -1 || rej_n !== -1) begin failed++; $display("FAIL clr_move_ignored got writes=%0d done=%0d rej=%0d exp 49 -1 -1", wr_cnt, done_n, rej_n); end
    tests++; if (dirty !== 0 || current_player !== 2'b01) begin failed++; $display("FAIL clr_board got dirty=%0d player=%b exp 0 01", dirty, current_player); end
  endtask

  task automatic test_reset_mid_scan();
    int dirty;
    exp_q.push_back({6'(heights[5] * 7 + 5), exp_player});
    move_col = 3'd5;
    move_valid = 1'b1;
    @(posedge Clk); #1;
    move_valid = 1'b0;
    clear_obs();
    for (int i = 0; i < 20 && scan_cnt == 0; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    tests++; if (scan_cnt == 0) begin failed++; $display("FAIL midscan_entry got no scan exp scan by cycle 20"); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({move_ready, busy, ram_address, ram_data, ram_wren, scan_enable, current_player,
         move_row, move_done, move_reject} !== RESET_OUTS) begin
      failed++;
      $display("FAIL midscan_reset_values got %b exp %b", {move_ready, busy, ram_address, ram_data,
               ram_wren, scan_enable, current_player, move_row, move_done, move_reject}, RESET_OUTS);
    end
    exp_q.delete();
    @(posedge Clk); @(posedge Clk); #1;
    reset = 1'b1;
    push_clear();
    clear_obs();
    wait_ready(150);
    dirty = 0;
    for (int i = 0; i < 49; i++) if (mem[i] !== 2'b00) dirty++;
    tests++; if (ready_n !== 99) begin failed++; $display("FAIL midscan_ready_cycle got %0d exp 99", ready_n); end
    tests++; if (dirty !== 0 || current_player !== 2'b01) begin failed++; $display("FAIL midscan_board got dirty=%0d player=%b exp 0 01", dirty, current_player); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_drop(3, "drop_col3_first");
    test_drop(3, "drop_col3_second");
    test_full_column();
    test_invalid_col();
    test_clear_priority();
    test_drop(4, "drop_after_clear");
    test_reset_mid_scan();
    test_drop(6, "drop_after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
